// File: rtl/dmem_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM state encoding and
// the wr_rd command encoding used on both requester ports and the memory port.
package dmem_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_e;

    localparam logic WR_RD_WRITE = 1'b0;
    localparam logic WR_RD_READ  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic with a priority pointer that flips to
// the loser after every contended grant; the owner FSM may force the pointer.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    input  logic force_ptr,
    input  logic force_ptr_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic ptr_b
);

    // ptr_q == 0 favours A, 1 favours B
    logic ptr_q;
    logic ptr_d;
    logic contended;

    assign contended = en && req_a && req_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = !ptr_q;
                gnt_b = ptr_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end

        ptr_d = ptr_q;
        if (force_ptr) begin
            ptr_d = force_ptr_b;
        end else if (contended) begin
            ptr_d = !ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_b = ptr_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port single-clock data-memory arbiter with one-cycle read return.
// Optional ownership locking is compiled in only when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_wr_rd,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  a_lock,
    input  logic                  b_req,
    input  logic                  b_wr_rd,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic                  b_lock,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wr_rd,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [15:0]           conflict_cnt,
    output state_e                dbg_state
);

    // Handshake: x_req (with its command fields) is held until x_gnt is seen
    // high in the same cycle; the command is consumed on that rising edge.
    state_e state_q, state_d;
    logic   gnt_a, gnt_b, ptr_b;
    logic   arb_req_a, arb_req_b;
    logic   force_ptr, force_ptr_b;

    logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [15:0]           conflict_q, conflict_d;
    logic                  unused_ptr;

    assign arb_req_a  = a_req && (state_q != LOCK_B);
    assign arb_req_b  = b_req && (state_q != LOCK_A);
    assign unused_ptr = ptr_b;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .en          (rst),
        .req_a       (arb_req_a),
        .req_b       (arb_req_b),
        .force_ptr   (force_ptr),
        .force_ptr_b (force_ptr_b),
        .gnt_a       (gnt_a),
        .gnt_b       (gnt_b),
        .ptr_b       (ptr_b)
    );

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    // lock_cnt counts grants already taken under the current lock, entry included
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        force_ptr   = 1'b0;
        force_ptr_b = 1'b0;
        unique case (state_q)
            ARB: begin
                if (gnt_a && a_lock) begin
                    if (LOCK_MAX <= 1) begin
                        force_ptr   = 1'b1;
                        force_ptr_b = 1'b1;
                    end else begin
                        state_d    = LOCK_A;
                        lock_cnt_d = CW'(1);
                    end
                end else if (gnt_b && b_lock) begin
                    if (LOCK_MAX <= 1) begin
                        force_ptr   = 1'b1;
                        force_ptr_b = 1'b0;
                    end else begin
                        state_d    = LOCK_B;
                        lock_cnt_d = CW'(1);
                    end
                end
            end
            LOCK_A: begin
                if (!a_req || (gnt_a && a_lock && lock_cnt_q >= LOCK_LAST)) begin
                    state_d     = ARB;
                    lock_cnt_d  = '0;
                    force_ptr   = 1'b1;
                    force_ptr_b = 1'b1;
                end else if (gnt_a && !a_lock) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (gnt_a) begin
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end
            end
            LOCK_B: begin
                if (!b_req || (gnt_b && b_lock && lock_cnt_q >= LOCK_LAST)) begin
                    state_d     = ARB;
                    lock_cnt_d  = '0;
                    force_ptr   = 1'b1;
                    force_ptr_b = 1'b0;
                end else if (gnt_b && !b_lock) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (gnt_b) begin
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;
    localparam int UNUSED_LOCK_MAX = LOCK_MAX;

    assign unused_lock = a_lock | b_lock;

    always_comb begin
        state_d     = ARB;
        force_ptr   = 1'b0;
        force_ptr_b = 1'b0;
    end
`endif

    // Memory port follows the granted command; otherwise address/data park
    always_comb begin
        mem_addr    = mem_addr_q;
        mem_data_in = mem_data_q;
        mem_wr_rd   = WR_RD_READ;
        if (gnt_a) begin
            mem_addr    = a_addr;
            mem_data_in = a_wdata;
            mem_wr_rd   = a_wr_rd;
        end else if (gnt_b) begin
            mem_addr    = b_addr;
            mem_data_in = b_wdata;
            mem_wr_rd   = b_wr_rd;
        end
        mem_addr_d = mem_addr;
        mem_data_d = mem_data_in;
    end

    always_comb begin
        a_rvalid_d = gnt_a && (a_wr_rd == WR_RD_READ);
        b_rvalid_d = gnt_b && (b_wr_rd == WR_RD_READ);
        a_rdata    = a_rvalid_q ? mem_data_out : a_rdata_q;
        b_rdata    = b_rvalid_q ? mem_data_out : b_rdata_q;
        a_rdata_d  = a_rdata;
        b_rdata_d  = b_rdata;
        conflict_d = conflict_q;
        if (a_req && b_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            conflict_q <= conflict_d;
        end
    end

    assign a_gnt        = gnt_a;
    assign b_gnt        = gnt_b;
    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign conflict_cnt = conflict_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model and
// per-port expected-read-data queues; lock steps run when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        a_req, a_wr_rd, a_lock, b_req, b_wr_rd, b_lock;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_wr_rd;
    logic [31:0] mem_data_out;
    logic [15:0] conflict_cnt;
    state_e      dbg_state;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LOCK_MAX(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_req        (a_req),
        .a_wr_rd      (a_wr_rd),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_lock       (a_lock),
        .b_req        (b_req),
        .b_wr_rd      (b_wr_rd),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_lock       (b_lock),
        .a_gnt        (a_gnt),
        .b_gnt        (b_gnt),
        .a_rvalid     (a_rvalid),
        .b_rvalid     (b_rvalid),
        .a_rdata      (a_rdata),
        .b_rdata      (b_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr_rd    (mem_wr_rd),
        .mem_data_out (mem_data_out),
        .conflict_cnt (conflict_cnt),
        .dbg_state    (dbg_state)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_arr [0:1023];
    logic [31:0] ref_mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_arr[i] = 32'(i * 1000 + 1);
        end
        mem_data_out = '0;
    end

    always @(posedge clk) begin
        mem_data_out <= mem_arr[mem_addr];
        if (mem_wr_rd == WR_RD_WRITE) mem_arr[mem_addr] = mem_data_in;
    end

    // scoreboard state
    int          checks = 0;
    int          errors = 0;
    logic [31:0] a_exp_q[$];
    logic [31:0] b_exp_q[$];
    logic        a_rv_exp, b_rv_exp;
    logic [31:0] a_last, b_last;
    logic [9:0]  last_addr;
    logic [31:0] last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rv();
        logic [31:0] e;
        check("a_rvalid", 32'(a_rvalid), 32'(a_rv_exp));
        if (a_rv_exp) begin
            if (a_exp_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL a_queue: observed empty expected entry");
            end else begin
                e = a_exp_q.pop_front();
                check("a_rdata", a_rdata, e);
                a_last = e;
            end
        end else begin
            check("a_rdata_hold", a_rdata, a_last);
        end
        check("b_rvalid", 32'(b_rvalid), 32'(b_rv_exp));
        if (b_rv_exp) begin
            if (b_exp_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL b_queue: observed empty expected entry");
            end else begin
                e = b_exp_q.pop_front();
                check("b_rdata", b_rdata, e);
                b_last = e;
            end
        end else begin
            check("b_rdata_hold", b_rdata, b_last);
        end
    endtask

    // driver: called at a falling edge, returns at the next falling edge
    task automatic cycle(input logic ar, input logic aw, input logic [9:0] aa, input logic [31:0] ad,
                         input logic al, input logic br, input logic bw, input logic [9:0] ba,
                         input logic [31:0] bd, input logic bl, input logic eg_a, input logic eg_b);
        check_rv();
        a_req = ar; a_wr_rd = aw; a_addr = aa; a_wdata = ad; a_lock = al;
        b_req = br; b_wr_rd = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
        #2;
        check("a_gnt", 32'(a_gnt), 32'(eg_a));
        check("b_gnt", 32'(b_gnt), 32'(eg_b));
        if (eg_a) begin
            check("mem_addr_a", 32'(mem_addr), 32'(aa));
            check("mem_wr_rd_a", 32'(mem_wr_rd), 32'(aw));
            check("mem_data_in_a", mem_data_in, ad);
            last_addr = aa; last_data = ad;
        end else if (eg_b) begin
            check("mem_addr_b", 32'(mem_addr), 32'(ba));
            check("mem_wr_rd_b", 32'(mem_wr_rd), 32'(bw));
            check("mem_data_in_b", mem_data_in, bd);
            last_addr = ba; last_data = bd;
        end else begin
            check("mem_wr_rd_idle", 32'(mem_wr_rd), 32'(WR_RD_READ));
            check("mem_addr_idle", 32'(mem_addr), 32'(last_addr));
            check("mem_data_in_idle", mem_data_in, last_data);
        end
        a_rv_exp = eg_a && (aw == WR_RD_READ);
        b_rv_exp = eg_b && (bw == WR_RD_READ);
        if (a_rv_exp) a_exp_q.push_back(ref_mem[aa]);
        if (b_rv_exp) b_exp_q.push_back(ref_mem[ba]);
        if (eg_a && aw == WR_RD_WRITE) ref_mem[aa] = ad;
        if (eg_b && bw == WR_RD_WRITE) ref_mem[ba] = bd;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_gnt"}, 32'(a_gnt), 32'd0);
        check({tag, "_b_gnt"}, 32'(b_gnt), 32'd0);
        check({tag, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
        check({tag, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
        check({tag, "_a_rdata"}, a_rdata, 32'd0);
        check({tag, "_b_rdata"}, b_rdata, 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_data_in"}, mem_data_in, 32'd0);
        check({tag, "_mem_wr_rd"}, 32'(mem_wr_rd), 32'd1);
        check({tag, "_conflict"}, 32'(conflict_cnt), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ARB));
    endtask

    task automatic clear_sb();
        a_exp_q.delete(); b_exp_q.delete();
        a_rv_exp = 1'b0; b_rv_exp = 1'b0;
        a_last = '0; b_last = '0;
        last_addr = '0; last_data = '0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i * 1000 + 1);
        clear_sb();
        // reset with both requests high: nothing may be granted
        rst = 1'b0;
        a_req = 1'b1; a_wr_rd = 1'b1; a_addr = 10'h3; a_wdata = '0; a_lock = 1'b0;
        b_req = 1'b1; b_wr_rd = 1'b1; b_addr = 10'h4; b_wdata = '0; b_lock = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_values("reset");
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b1;
        idle();

        // A reads word 3 alone
        cycle(1'b1, 1'b1, 10'h003, 32'h0, 1'b0, 1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("word3_value", a_exp_q[0], 32'd3001);
        idle();
        check("a_last_3001", a_rdata, 32'd3001);

        // both read every cycle for 4 cycles: A,B,A,B
        cycle(1'b1, 1'b1, 10'h005, 32'h0, 1'b0, 1'b1, 1'b1, 10'h006, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 10'h005, 32'h0, 1'b0, 1'b1, 1'b1, 10'h006, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 10'h005, 32'h0, 1'b0, 1'b1, 1'b1, 10'h006, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 10'h005, 32'h0, 1'b0, 1'b1, 1'b1, 10'h006, 32'h0, 1'b0, 1'b0, 1'b1);
        check("conflict_4", 32'(conflict_cnt), 32'd4);
        idle();

        // B writes 0x1234 to 0x010, then A reads it back
        cycle(1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h010, 32'h1234, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 10'h010, 32'h0, 1'b0, 1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        check("a_rd_after_b_wr", a_rdata, 32'h1234);
        idle();

        // back-to-back reads from A
        cycle(1'b1, 1'b1, 10'h001, 32'h0, 1'b0, 1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 10'h002, 32'h0, 1'b0, 1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();

`ifdef DMEM_ARB_LOCK_EN
        // A holds the lock against a pending B: 8 A grants, then B
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 10'(i + 32), 32'h0, 1'b1, 1'b1, 1'b1, 10'h040, 32'h0, 1'b0, 1'b1, 1'b0);
            if (i < 7) check("state_lock_a", 32'(dbg_state), 32'(LOCK_A));
        end
        check("state_after_lock", 32'(dbg_state), 32'(ARB));
        cycle(1'b1, 1'b1, 10'h028, 32'h0, 1'b1, 1'b1, 1'b1, 10'h040, 32'h0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
`endif

        // reset in the cycle after a granted read: the read is discarded
        cycle(1'b1, 1'b1, 10'h007, 32'h0, 1'b0, 1'b0, 1'b1, 10'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        check_reset_values("midreset");
        clear_sb();
        @(negedge clk);
        check_reset_values("midreset_hold");
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b1;
        idle();
        idle();

        // saturation of the conflict counter
        a_req = 1'b1; a_wr_rd = WR_RD_WRITE; a_addr = 10'h020; a_wdata = '0; a_lock = 1'b0;
        b_req = 1'b1; b_wr_rd = WR_RD_WRITE; b_addr = 10'h020; b_wdata = '0; b_lock = 1'b0;
        ref_mem[10'h020] = '0;
        for (int i = 0; i < 65534; i++) @(negedge clk);
        check("conflict_fffe", 32'(conflict_cnt), 32'hFFFE);
        @(negedge clk);
        check("conflict_ffff", 32'(conflict_cnt), 32'hFFFF);
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("conflict_sat", 32'(conflict_cnt), 32'hFFFF);
        last_addr = 10'h020; last_data = '0;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
